// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch front end.
//   fetch_state_t    : fetch controller states (FETCH, HOLD, DRAIN)
//   NOP_INSTR        : instruction presented to the decoder while nothing is fetched
//   DEFAULT_RESET_PC : default address of the first fetch after reset
//   word_align()     : clears the byte-offset bits of an address
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory and presents the returned word to the decoder until it is consumed
// or flushed by a redirect.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req, imem_addr     : fetch request and word-aligned address
//   imem_ack, imem_rdata    : memory response (honoured only while imem_req=1)
//   instr_valid, instr, pc  : fetched instruction and its address
//   pc_plus4                : pc + 4 (wrapping), link value for JAL/JALR
//   instr_ready             : decoder consumes instr this cycle
//   redirect_valid/_target  : flush and refetch from a new address
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  pending_pc;
    logic [31:0]  instr_q;
    logic [31:0]  pc_q;
    logic         req_q;
    logic         valid_q;
    logic [31:0]  target;

    assign target = word_align(redirect_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!req_q) begin
                        // First cycle out of reset: nothing outstanding yet,
                        // so a redirect can retarget the fetch directly.
                        req_q <= 1'b1;
                        if (redirect_valid) fetch_pc <= target;
                    end else if (imem_ack) begin
                        if (redirect_valid) begin
                            fetch_pc <= target;
                        end else begin
                            instr_q  <= imem_rdata;
                            pc_q     <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            valid_q  <= 1'b1;
                            req_q    <= 1'b0;
                            state    <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Request already in flight: keep the address stable
                        // and discard its data when it finally returns.
                        pending_pc <= target;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        fetch_pc <= redirect_valid ? target : pending_pc;
                        state    <= FETCH;
                    end else if (redirect_valid) begin
                        pending_pc <= target;
                    end
                end
                HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        if (redirect_valid) fetch_pc <= target;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory latency,
// consumer back-pressure and redirects, checked against a transaction-level
// model of the architectural PC stream.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, pc, pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
    );

    // Second instance exercising the top-of-address-space reset vector;
    // its memory acks every request immediately and the decoder always consumes.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(32'hCAFE_0001),
        .instr_valid(w_valid), .instr(w_instr), .pc(w_pc), .pc_plus4(w_pc4),
        .instr_ready(1'b1),
        .redirect_valid(1'b0), .redirect_target(32'h0000_0000)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- instruction memory model ----------------
    int  mem_delay = 0;      // fixed latency per request, -1 = random 0..3
    bit  spurious = 1'b0;    // random acks while no request is pending
    bit  mem_busy = 1'b0;
    int  wait_cnt = 0;

    always @(negedge clk) begin
        if (imem_req && rst_n) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                wait_cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_busy   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            mem_busy   = 1'b0;
            imem_ack   = spurious && ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
    end

    // ---------------- reference model / monitor ----------------
    // Architectural rule: the next delivered instruction sits at the latest
    // redirect target, or at the last consumed pc + 4. Data of a request that
    // saw a redirect while in flight is never delivered.
    logic [31:0] exp_pc = '0;
    bit          p_valid, p_ready, p_redirect, p_open, expect_deliv, taint;
    logic [31:0] p_instr, p_pc, p_addr;
    int unsigned idle = 0, since_rst = 0, cyc = 0;
    bit          rec_en = 1'b0;
    logic [31:0] acked_q[$];
    logic [31:0] deliv_pc_q[$];
    int unsigned deliv_cyc_q[$];

    always @(negedge clk) begin
        #4;
        cyc++;
        if (!rst_n) begin
            check_eq("rst_req", 32'(imem_req), 32'd0);
            check_eq("rst_addr", imem_addr, 32'h0);
            check_eq("rst_valid", 32'(instr_valid), 32'd0);
            check_eq("rst_instr", instr, NOP);
            check_eq("rst_pc", pc, 32'h0);
            check_eq("rst_pc4", pc_plus4, 32'h4);
            exp_pc = '0; p_valid = 0; p_ready = 0; p_redirect = 0; p_open = 0;
            expect_deliv = 0; taint = 0; idle = 0; since_rst = 0;
        end else begin
            since_rst++;
            if (since_rst == 2) check_eq("req_after_reset", 32'(imem_req), 32'd1);
            if (imem_req) check_eq("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (p_open) begin
                check_eq("req_held", 32'(imem_req), 32'd1);
                check_eq("addr_stable", imem_addr, p_addr);
            end
            if (p_valid && !p_ready && !p_redirect) begin
                check_eq("hold_valid", 32'(instr_valid), 32'd1);
                check_eq("hold_instr", instr, p_instr);
                check_eq("hold_pc", pc, p_pc);
            end else begin
                check_eq("deliver", 32'(instr_valid), 32'(expect_deliv));
                if (instr_valid) begin
                    check_eq("deliv_pc", pc, exp_pc);
                    check_eq("deliv_instr", instr, mem_word(pc));
                    check_eq("deliv_pc4", pc_plus4, pc + 32'd4);
                    if (rec_en) begin
                        deliv_pc_q.push_back(pc);
                        deliv_cyc_q.push_back(cyc);
                    end
                end
            end
            if (instr_valid) check_eq("req_in_hold", 32'(imem_req), 32'd0);

            expect_deliv = imem_req && imem_ack && !redirect_valid && !taint;
            if (expect_deliv) begin
                check_eq("fetch_addr", imem_addr, exp_pc);
                if (rec_en) acked_q.push_back(imem_addr);
            end
            if (imem_req && imem_ack) taint = 0;
            else if (imem_req && redirect_valid) taint = 1;

            if (redirect_valid) exp_pc = redirect_target & 32'hFFFF_FFFC;
            else if (instr_valid && instr_ready) exp_pc = pc + 32'd4;

            p_valid = instr_valid; p_ready = instr_ready; p_redirect = redirect_valid;
            p_instr = instr; p_pc = pc; p_addr = imem_addr;
            p_open = imem_req && !imem_ack;
            idle = instr_valid ? 0 : idle + 1;
            if (idle > 150) begin
                check_eq("stall_cycles", idle, 32'd0);
                idle = 0;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_for_valid(input int unsigned limit);
        int unsigned n = 0;
        do begin
            @(negedge clk); #4; n++;
        end while (!instr_valid && n < limit);
        check_eq("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    initial begin
        // ---- back-to-back fetch with zero-wait memory ----
        instr_ready = 1'b1;
        do_reset();
        rec_en = 1'b1;
        repeat (12) @(negedge clk);
        #4 rec_en = 1'b0;
        check_eq("seq_count", 32'(acked_q.size() >= 4 && deliv_pc_q.size() >= 4), 32'd1);
        for (int unsigned i = 0; i < 4 && i < acked_q.size() && i < deliv_pc_q.size(); i++) begin
            check_eq("seq_addr", acked_q[i], 32'(i * 4));
            check_eq("seq_pc", deliv_pc_q[i], 32'(i * 4));
        end
        for (int unsigned i = 1; i < deliv_cyc_q.size(); i++)
            check_eq("seq_spacing", deliv_cyc_q[i] - deliv_cyc_q[i-1], 32'd2);

        // ---- wrapping reset vector ----
        @(negedge clk) rst_n = 1'b0;
        #4;
        check_eq("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        check_eq("wrap_rst_pc4", w_pc4, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int unsigned i = 0; i < 6 && !w_valid; i++) begin
            @(negedge clk); #4;
        end
        check_eq("wrap_valid", 32'(w_valid), 32'd1);
        check_eq("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", w_pc4, 32'h0);
        @(negedge clk); #4;
        check_eq("wrap_next_req", 32'(w_req), 32'd1);
        check_eq("wrap_next_addr", w_addr, 32'h0);

        // ---- redirect from HOLD (pc=8) to an unaligned target ----
        instr_ready = 1'b0;
        do_reset();
        wait_for_valid(10);
        @(negedge clk) begin redirect_valid = 1'b1; redirect_target = 32'h8; end
        @(negedge clk) redirect_valid = 1'b0;
        wait_for_valid(10);
        check_eq("hold_at_8", pc, 32'h8);
        @(negedge clk) begin redirect_valid = 1'b1; redirect_target = 32'h0000_0103; end
        @(negedge clk) redirect_valid = 1'b0;
        #4;
        check_eq("flush_valid", 32'(instr_valid), 32'd0);
        check_eq("flush_addr", imem_addr, 32'h0000_0100);
        check_eq("flush_req", 32'(imem_req), 32'd1);

        // ---- redirect during a slow request at 0x10 ----
        wait_for_valid(10);
        @(negedge clk) begin mem_delay = 3; redirect_valid = 1'b1; redirect_target = 32'h10; end
        @(negedge clk) redirect_valid = 1'b0;
        #4 check_eq("slow_addr0", imem_addr, 32'h10);
        @(negedge clk) begin redirect_valid = 1'b1; redirect_target = 32'h40; end
        #4 check_eq("slow_addr1", imem_addr, 32'h10);
        @(negedge clk) begin redirect_valid = 1'b0; mem_delay = 0; end
        #4 check_eq("slow_addr2", imem_addr, 32'h10);
        @(negedge clk); #4;
        check_eq("slow_addr3", imem_addr, 32'h10);
        check_eq("slow_ack3", 32'(imem_ack), 32'd1);
        @(negedge clk); #4;
        check_eq("drain_next_addr", imem_addr, 32'h40);
        check_eq("drain_no_valid", 32'(instr_valid), 32'd0);
        wait_for_valid(10);
        check_eq("drain_pc", pc, 32'h40);

        // ---- newer redirect in the ack cycle of a drain ----
        @(negedge clk) begin instr_ready = 1'b1; mem_delay = 2; end
        @(negedge clk) begin instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40; end
        #4 check_eq("d2_addr0", imem_addr, 32'h44);
        @(negedge clk) redirect_valid = 1'b0;
        @(negedge clk) begin redirect_valid = 1'b1; redirect_target = 32'h80; mem_delay = 0; end
        #4 check_eq("d2_ack", 32'(imem_ack), 32'd1);
        @(negedge clk) redirect_valid = 1'b0;
        #4 check_eq("d2_next_addr", imem_addr, 32'h80);
        wait_for_valid(10);
        check_eq("d2_pc", pc, 32'h80);

        // ---- stall in HOLD, then asynchronous reset ----
        begin
            logic [31:0] s_instr, s_pc;
            s_instr = instr; s_pc = pc;
            for (int unsigned i = 0; i < 5; i++) begin
                @(negedge clk); #4;
                check_eq("stall_instr", instr, s_instr);
                check_eq("stall_pc", pc, s_pc);
                check_eq("stall_req", 32'(imem_req), 32'd0);
            end
        end
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check_eq("async_valid", 32'(instr_valid), 32'd0);
        check_eq("async_instr", instr, NOP);
        check_eq("async_pc", pc, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // ---- randomized traffic ----
        mem_delay = -1;
        spurious = 1'b1;
        for (int unsigned i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = (i % 1000 != 999);
            instr_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : ($urandom & 32'h0000_0FFF);
        end
        @(negedge clk) begin redirect_valid = 1'b0; rst_n = 1'b1; end
        repeat (3) @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  fetch request to instruction memory.
REQ-005 imem_addr  out  32  word-aligned fetch address; bits[1:0] always 0.
REQ-006 imem_ack  in  1  memory has returned imem_rdata this cycle; honoured only while imem_req=1.
REQ-007 imem_rdata  in  32  instruction word; valid only when imem_ack=1.
REQ-008 instr_valid  out  1  instr/pc hold a fetched instruction for the decoder.
REQ-009 instr  out  32  instruction word presented to the decoder.
REQ-010 pc  out  32  address of instr.
REQ-011 pc_plus4  out  32  pc+4, modulo 2^32 (JAL/JALR link value).
REQ-012 instr_ready  in  1  decoder/execute consumes instr this cycle.
REQ-013 redirect_valid  in  1  taken branch/JAL/JALR; flush and refetch.
REQ-014 redirect_target  in  32  new PC; bits[1:0] ignored, treated as 0.

Function
REQ-015 States SHALL be FETCH, HOLD, DRAIN; at most one memory request outstanding.
REQ-016 FETCH: imem_req=1, imem_addr=fetch_pc; imem_addr SHALL stay stable until imem_ack.
REQ-017 FETCH, ack, no redirect: on the next edge, instr<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, -> HOLD.
REQ-018 FETCH, ack and redirect in the same cycle: rdata discarded, fetch_pc<=target, stay FETCH, instr_valid stays 0.
REQ-019 FETCH, redirect without ack: pending_pc<=target, -> DRAIN.
REQ-020 DRAIN: imem_req=1 with the old imem_addr; on ack, rdata discarded, fetch_pc<=pending_pc, -> FETCH.
REQ-021 DRAIN, further redirect: pending_pc SHALL take the newest target; a same-cycle redirect and ack SHALL use the new target.
REQ-022 HOLD: instr_valid=1, imem_req=0; instr and pc stable until consumed or flushed.
REQ-023 HOLD, instr_ready, no redirect: -> FETCH next cycle; instr_valid=0.
REQ-024 HOLD, redirect, with or without instr_ready: fetch_pc<=target, instr_valid=0 next cycle, -> FETCH.
REQ-025 Redirect SHALL override instr_ready in all cases.
REQ-026 Latency: ack cycle N -> instr_valid=1 at cycle N+1; throughput one instruction per two cycles at zero memory wait.
REQ-027 The fetch_pc increment SHALL wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000; pc_plus4 wraps the same way.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.
REQ-029 instr_valid SHALL be registered, not combinationally dependent on imem_ack.

Reset
REQ-030 While rst_n=0: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), pc=RESET_PC, pc_plus4=RESET_PC+4, fetch_pc=RESET_PC, state=FETCH.
REQ-031 First imem_req=1 SHALL occur in the first cycle after rst_n deasserts.
REQ-032 Reset mid-request or mid-DRAIN SHALL abandon the transaction; a late ack after reset SHALL be accepted as the RESET_PC fetch only if it arrives with imem_req=1.

Structure
REQ-033 cpu_pkg SHALL hold the fetch state enum, the NOP constant 32'h0000_0013, and the RESET_PC default.
REQ-034 Single module; no sub-module needed. The PC incrementer is inline.

Verification
REQ-035 Reset, memory acks every request in the same cycle, instr_ready=1 -> imem_addr sequence 0,4,8,C; pc 0,4,8,C; instr_valid toggles every other cycle.
REQ-036 In HOLD (pc=8), redirect_valid=1, target=32'h0000_0103 -> instr_valid=0 next cycle; next imem_addr=32'h0000_0100.
REQ-037 Request at 0x10 with 3-cycle ack delay; redirect to 0x40 in cycle 1 -> address stays 0x10 until ack; data discarded; next imem_addr=0x40; instr_valid never 1 for 0x10.
REQ-038 Start in DRAIN with target 0x40, then redirect to 0x80 in the ack cycle -> next fetch is 0x80.
REQ-039 RESET_PC=32'hFFFF_FFFC, ready=1 -> pc=FFFF_FFFC, pc_plus4=0, next imem_addr=0.
REQ-040 Hold instr_ready=0 for 5 cycles in HOLD -> instr/pc stable, imem_req=0; pulse rst_n low mid-HOLD -> instr_valid=0 and instr=NOP at once (async).
